mprj_stim_sequencer: RTL and testbench

//  Shares the user-area stimulus pins between two requesters: management (M) and user logic (U).

---
 rtl/mprj_stim_pkg.sv | 12 +
 rtl/mprj_stim_rr_arb.sv | 22 ++
 rtl/mprj_stim_sequencer.sv | 86 ++++++++
 tb/tb_mprj_stim_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mprj_stim_pkg.sv
// mprj_stim_pkg: shared state, owner and word types for the mprj stimulus sequencer
package mprj_stim_pkg;
    localparam int STIM_CHK_W = 16;
    localparam int STIM_STS_W = 4;
    localparam logic OWN_M = 1'b0;
    localparam logic OWN_U = 1'b1;
    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
    typedef struct packed {
        logic [STIM_STS_W-1:0] sts;
        logic [STIM_CHK_W-1:0] chk;
    } stim_word_t;
endpackage

// File: rtl/mprj_stim_rr_arb.sv
// mprj_stim_rr_arb: two-way round-robin grant (bit0=M, bit1=U), last winner loses ties
module mprj_stim_rr_arb
    import mprj_stim_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic rr_last;
    always_comb begin
        gnt[0] = en && req[0] && (!req[1] || rr_last == OWN_U);
        gnt[1] = en && req[1] && (!req[0] || rr_last == OWN_M);
    end
    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= OWN_U;
        else if (en && |gnt)
            rr_last <= gnt[1];
    end
endmodule

// File: rtl/mprj_stim_sequencer.sv
// mprj_stim_sequencer: arbitrates M/U stimulus words onto mprj_io pins, holding each HOLD_CYCLES clocks.
// Optional even parity output when MPRJ_STIM_PARITY_EN is defined.
module mprj_stim_sequencer
    import mprj_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 64,
    parameter int CHK_W       = 16,
    parameter int STS_W       = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [STS_W+CHK_W-1:0] m_data,
    input  logic                   u_valid,
    output logic                   u_ready,
    input  logic [STS_W+CHK_W-1:0] u_data,
    output logic [CHK_W-1:0]       chk_o,
    output logic [STS_W-1:0]       sts_o,
    output logic [STS_W+CHK_W-1:0] io_oeb_o,
    output logic                   busy_o,
    output logic                   owner_o,
    output logic                   par_o
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = STS_W + CHK_W;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    gnt;
    logic          slot, accept;
    logic [DW-1:0] acc_data, pins;

    mprj_stim_rr_arb u_arb (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .req ({u_valid, m_valid}),
        .en  (slot),
        .gnt (gnt)
    );

    // Reset masks the accept slot so no ready escapes while the word would be discarded.
    always_comb begin
        slot      = !wb_rst_i && (state == ST_IDLE || cnt == '0);
        accept    = |gnt;
        m_ready   = gnt[0];
        u_ready   = gnt[1];
        acc_data  = gnt[1] ? u_data : m_data;
        state_nxt = (accept || (state == ST_HOLD && cnt != '0)) ? ST_HOLD : ST_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pins     <= '0;
            owner_o  <= OWN_M;
            io_oeb_o <= '1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= CW'(HOLD_CYCLES - 1);
                pins     <= acc_data;
                owner_o  <= gnt[1];
                io_oeb_o <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign chk_o  = pins[CHK_W-1:0];
    assign sts_o  = pins[DW-1:CHK_W];
    assign busy_o = (state == ST_HOLD);

`ifdef MPRJ_STIM_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            par_o <= 1'b0;
        else if (accept)
            par_o <= ^acc_data;
    end
`else
    assign par_o = 1'b0;
`endif
endmodule

// File: tb/tb_mprj_stim_sequencer.sv
// tb_mprj_stim_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_mprj_stim_sequencer;
    import mprj_stim_pkg::*;

    localparam int HOLD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_valid = 1'b0, u_valid = 1'b0;
    logic [19:0] m_data = '0, u_data = '0;
    logic        m_ready, u_ready, busy_o, owner_o, par_o;
    logic [15:0] chk_o;
    logic [3:0]  sts_o;
    logic [19:0] io_oeb_o;

    int checks = 0;
    int errors = 0;

    mprj_stim_sequencer #(.HOLD_CYCLES(HOLD), .CHK_W(16), .STS_W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .u_valid  (u_valid),
        .u_ready  (u_ready),
        .u_data   (u_data),
        .chk_o    (chk_o),
        .sts_o    (sts_o),
        .io_oeb_o (io_oeb_o),
        .busy_o   (busy_o),
        .owner_o  (owner_o),
        .par_o    (par_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [19:0] md;
        logic        uv;
        logic [19:0] ud;
        logic        emr;
        logic        eur;
        logic        eown;
        logic        epar;
        logic [19:0] epins;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n, HOLD);
    endtask

    function automatic logic exp_par(input logic p);
`ifdef MPRJ_STIM_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] w [3];
        int k, last, cyc;
        logic acc;
        w[0] = 20'h3_1968; w[1] = 20'h6_1DCD; w[2] = 20'hC_AB51;
        tbl[0] = '{1'b1, 20'hA_AB40, 1'b0, 20'h0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 20'hA_AB40};
        tbl[1] = '{1'b1, 20'h2_1234, 1'b1, 20'h5_0001, 1'b0, 1'b1, 1'b1, 1'b1, 20'h5_0001};
        tbl[2] = '{1'b1, 20'h5_0003, 1'b1, 20'h7_1DCD, 1'b1, 1'b0, 1'b0, 1'b0, 20'h5_0003};
        tbl[3] = '{1'b0, 20'h0_0000, 1'b1, 20'hC_AB51, 1'b0, 1'b1, 1'b1, 1'b0, 20'hC_AB51};
        tbl[4] = '{1'b1, 20'hF_FFFE, 1'b0, 20'h0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 20'hF_FFFE};
        tbl[5] = '{1'b0, 20'h0_0000, 1'b1, 20'h0_0007, 1'b0, 1'b1, 1'b1, 1'b1, 20'h0_0007};

        // Reset with both requesters already offering (tie scenario follows)
        m_valid = 1'b1; m_data = 20'hA_AB40;
        u_valid = 1'b1; u_data = 20'h3_1968;
        repeat (4) @(negedge clk);
        check("rst_chk", chk_o, 16'h0);
        check("rst_sts", sts_o, 4'h0);
        check("rst_oeb", io_oeb_o, 20'hFFFFF);
        check("rst_busy", busy_o, 1'b0);
        check("rst_owner", owner_o, 1'b0);
        check("rst_par", par_o, 1'b0);
        check("rst_ready", {m_ready, u_ready}, 2'b00);

        rst = 1'b0;
        #1;
        check("tie_first_ready", {m_ready, u_ready}, 2'b10);
        @(negedge clk);
        m_valid = 1'b0;
        check("tie_m_pins", {sts_o, chk_o}, 20'hA_AB40);
        check("tie_m_owner", owner_o, 1'b0);
        check("tie_oeb", io_oeb_o, 20'h0);
        check("tie_busy", busy_o, 1'b1);
        k = 0;
        while (owner_o !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tie_u_delay", k, HOLD);
        check("tie_u_pins", {sts_o, chk_o}, 20'h3_1968);
        u_valid = 1'b0;
        wait_idle("tie_idle");

        // Back-to-back U words
        u_valid = 1'b1; u_data = w[0];
        k = 0; last = 0; cyc = 0;
        while (k < 3 && cyc < 400) begin
            #1;
            if (m_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_m_ready: got %0b expected 0", m_ready);
            end
            acc = u_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin
                check("b2b_pins", {sts_o, chk_o}, w[k]);
                if (k > 0) check("b2b_spacing", cyc - last, HOLD);
                last = cyc;
                k++;
                if (k < 3) u_data = w[k];
                else u_valid = 1'b0;
            end
        end
        checks++;
        check("b2b_count", k, 3);
        wait_idle("b2b_idle");

        // Reset mid-HOLD at cnt=20 with an M word pending
        u_valid = 1'b1; u_data = 20'h3_1968;
        #1;
        check("mid_u_ready", u_ready, 1'b1);
        @(negedge clk);
        u_valid = 1'b0;
        m_valid = 1'b1; m_data = 20'hA_AB40;
        repeat (43) @(negedge clk);
        check("mid_hold_pins", {sts_o, chk_o}, 20'h3_1968);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {m_ready, u_ready}, 2'b00);
        @(negedge clk);
        check("mid_rst_pins", {sts_o, chk_o}, 20'h0);
        check("mid_rst_oeb", io_oeb_o, 20'hFFFFF);
        check("mid_rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_post_ready", {m_ready, u_ready}, 2'b10);
        @(negedge clk);
        m_valid = 1'b0;
        check("mid_post_pins", {sts_o, chk_o}, 20'hA_AB40);
        check("mid_post_oeb", io_oeb_o, 20'h0);
        check("mid_post_owner", owner_o, 1'b0);
        wait_idle("mid_idle");

        // Single-word vectors, each started from IDLE
        for (int i = 0; i < 6; i++) begin
            m_valid = tbl[i].mv; m_data = tbl[i].md;
            u_valid = tbl[i].uv; u_data = tbl[i].ud;
            #1;
            check($sformatf("vec%0d_m_ready", i), m_ready, tbl[i].emr);
            check($sformatf("vec%0d_u_ready", i), u_ready, tbl[i].eur);
            @(negedge clk);
            m_valid = 1'b0; u_valid = 1'b0;
            check($sformatf("vec%0d_pins", i), {sts_o, chk_o}, tbl[i].epins);
            check($sformatf("vec%0d_owner", i), owner_o, tbl[i].eown);
            check($sformatf("vec%0d_par", i), par_o, exp_par(tbl[i].epar));
            check($sformatf("vec%0d_oeb", i), io_oeb_o, 20'h0);
            check($sformatf("vec%0d_busy", i), busy_o, 1'b1);
            wait_idle($sformatf("vec%0d_hold", i));
            check($sformatf("vec%0d_retain", i), {sts_o, chk_o}, tbl[i].epins);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
